serial_addsub: RTL

- Parametrised, multi-cycle adder/subtractor that processes DIGIT bits per clock, LSB digit first.
- Generalises the single-bit combinational adders to a WIDTH-bit operation with carry-in, subtract mode, carry-out and signed overflow.
- Uses a start/busy/done handshake.
- Sits in datapaths that trade latency for area: one DIGIT-wide adder slice is reused over WIDTH/DIGIT cycles.

---
 rtl/serial_addsub.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice reused over WIDTH/DIGIT cycles,
// LSB digit first, with a start/busy/done handshake.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned StepW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned DigW  = DIGIT + 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NSTEP - 1);

  if (WIDTH % DIGIT != 0) begin : gen_bad_digit
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   shadow_q;
  logic [WIDTH-1:0]   shadow_d;
  logic               carry_q;
  logic [StepW-1:0]   step_q;

  int unsigned        base;
  logic [DIGIT-1:0]   dig_a;
  logic [DIGIT-1:0]   dig_b;
  logic [DIGIT-1:0]   dig_sum;
  logic [DIGIT:0]     dig_ext;
  logic               dig_cout;
  logic               msb_cin;

  // Single digit slice; the carry into the top bit of the slice is recovered from the sum bit.
  always_comb begin
    base     = 32'(step_q) * DIGIT;
    dig_a    = a_q[base +: DIGIT];
    dig_b    = b_q[base +: DIGIT];
    dig_ext  = {1'b0, dig_a} + {1'b0, dig_b} + DigW'(carry_q);
    dig_sum  = dig_ext[DIGIT-1:0];
    dig_cout = dig_ext[DIGIT];
    msb_cin  = dig_sum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
    shadow_d = shadow_q;
    shadow_d[base +: DIGIT] = dig_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      step_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + ~cin, so fold the inversion in at latch time.
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= cin ^ sub;
            shadow_q <= '0;
            step_q   <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          shadow_q <= shadow_d;
          carry_q  <= dig_cout;
          step_q   <= step_q + 1'b1;
          if (step_q == LastStep) begin
            sum     <= shadow_d;
            cout    <= dig_cout;
            ovf     <= dig_cout ^ msb_cin;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
